// File: rtl/mem_cfg_pkg.sv
// mem_cfg_pkg: memory access width encoding shared by the arbiter and its clients.
//   mem_width_t : BYTE / HALF / WORD access size carried with each memory command.
package mem_cfg_pkg;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_width_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one of NUM_CH requesters access to a single memory port.
//   clk_i, rst_i        : clock and synchronous active-high reset
//   req_i, lock_i, we_i : per-channel request, grant-lock request and write enable
//   addr_i, wdata_i     : per-channel address and write data
//   width_i             : per-channel access width
//   gnt_o               : one-hot grant, combinational from req_i and arbiter state
//   rvalid_o, rdata_o   : one-hot read-valid and read data, one cycle after a read
//   mem_*_o, mem_data_i : memory-side command and read data
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration;
// without it the lowest-index requesting channel wins.
module mem_port_arbiter
   import mem_cfg_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_CH-1:0]             req_i,
   input  logic [NUM_CH-1:0]             lock_i,
   input  logic [NUM_CH-1:0]             we_i,
   input  logic [NUM_CH-1:0][ADDR_W-1:0] addr_i,
   input  logic [NUM_CH-1:0][DATA_W-1:0] wdata_i,
   input  mem_width_t [NUM_CH-1:0]       width_i,
   output logic [NUM_CH-1:0]             gnt_o,
   output logic [NUM_CH-1:0]             rvalid_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic [ADDR_W-1:0]             mem_addr_o,
   output logic [DATA_W-1:0]             mem_data_o,
   output logic                          mem_we_o,
   output mem_width_t                    mem_width_o,
   input  logic [DATA_W-1:0]             mem_data_i
);
   localparam int IDX_W = $clog2(NUM_CH);
   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic {UNLOCKED, LOCKED} state_t;
   state_t            state_q, state_d;
   idx_t              lock_ch_q, lock_ch_d, gidx, cand;
   logic [NUM_CH-1:0] rvalid_q, rvalid_d;
   logic              found, held, gnt_any;
`ifdef MEM_ARB_RR_EN
   idx_t              ptr_q, ptr_d;
`endif
   // The lock survives only while its owner keeps both request and lock high;
   // otherwise this very cycle falls back to normal arbitration.
   assign held = (state_q == LOCKED) && req_i[lock_ch_q] && lock_i[lock_ch_q];
   always_comb begin
      found = held;
      gidx = lock_ch_q;
      cand = '0;
      for (int k = 0; k < NUM_CH; k++) begin
`ifdef MEM_ARB_RR_EN
         cand = idx_t'((int'(ptr_q) + k) % NUM_CH);
`else
         cand = idx_t'(k);
`endif
         if (!found && req_i[cand]) begin
            found = 1'b1;
            gidx = cand;
         end
      end
   end
   assign gnt_any     = found && !rst_i;
   assign gnt_o       = gnt_any ? NUM_CH'(1) << gidx : '0;
   assign mem_we_o    = gnt_any && we_i[gidx];
   assign mem_addr_o  = gnt_any ? addr_i[gidx] : '0;
   assign mem_data_o  = gnt_any ? wdata_i[gidx] : '0;
   assign mem_width_o = gnt_any ? width_i[gidx] : BYTE;
   assign rvalid_d    = gnt_o & ~we_i;
   assign state_d     = (gnt_any && lock_i[gidx]) ? LOCKED : UNLOCKED;
   assign lock_ch_d   = gnt_any ? gidx : lock_ch_q;
`ifdef MEM_ARB_RR_EN
   assign ptr_d       = !gnt_any ? ptr_q : (gidx == idx_t'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
`endif
   // Gating with rst_i drops a read accepted just before reset asserts.
   assign rvalid_o    = rst_i ? '0 : rvalid_q;
   assign rdata_o     = (|rvalid_o) ? mem_data_i : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= UNLOCKED;
         lock_ch_q <= '0;
         rvalid_q  <= '0;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
         rvalid_q  <= rvalid_d;
`ifdef MEM_ARB_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end
endmodule
